terrain_gen: RTL and testbench

//  Parametrised successor to the fixed terrain table: builds a random-walk heightmap in on-chip RAM

---
 rtl/terrain_pkg.sv | 27 ++
 rtl/terrain_ram.sv | 35 +++
 rtl/terrain_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_terrain_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/terrain_pkg.sv
// Shared types and helpers for the terrain heightmap generator.
// The optional TERRAIN_SMOOTH_EN macro (see terrain_gen.sv) adds a 3-tap smoothing filter to generation.
package terrain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        GEN,
        FIN,
        CRD,
        CWR
    } state_e;

    // Galois feedback mask for the default 16-bit LFSR
    localparam logic [15:0] LFSR_TAPS_DEF = 16'hB400;

    function automatic int clampInt(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/terrain_ram.sv
// Heightmap storage: true dual-port RAM with a synchronous read/write port A
// and a synchronous read-only port B. There is no reset, so it maps onto block RAM.
module terrain_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic [AW-1:0]    a_addr_i,
    input  logic             a_we_i,
    input  logic [WIDTH-1:0] a_wdata_i,
    output logic [WIDTH-1:0] a_rdata_o,
    input  logic [AW-1:0]    b_addr_i,
    output logic [WIDTH-1:0] b_rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] aRdata_q;
    logic [WIDTH-1:0] bRdata_q;

    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem[a_addr_i] <= a_wdata_i;
        end
        aRdata_q <= mem[a_addr_i];
    end

    always_ff @(posedge clk_i) begin
        bRdata_q <= mem[b_addr_i];
    end

    assign a_rdata_o = aRdata_q;
    assign b_rdata_o = bRdata_q;

endmodule

// File: rtl/terrain_gen.sv
// Random-walk heightmap generator with crater carving and a free-running column read port.
// Define TERRAIN_SMOOTH_EN to pass generated heights through a (1,2,1)/4 filter before storage.
module terrain_gen
    import terrain_pkg::*;
#(
    parameter int NUM_COLS = 640,
    parameter int HEIGHT_W = 9,
    parameter int MIN_H    = 120,
    parameter int MAX_H    = 400,
    parameter int STEP_MAX = 3,
    parameter int LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEF),
    parameter int COL_W    = $clog2(NUM_COLS)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [LFSR_W-1:0]   seed_i,
    input  logic                crater_req_i,
    input  logic [COL_W-1:0]    crater_col_i,
    input  logic [5:0]          crater_r_i,
    output logic                crater_ack_o,
    output logic                busy_o,
    output logic                done_o,
    input  logic [COL_W-1:0]    rd_col_i,
    output logic [HEIGHT_W-1:0] rd_height_o
);

    localparam int K     = $clog2(2*STEP_MAX+1);
    localparam int CNT_W = $clog2(NUM_COLS+1);
    localparam int MID_H = (MIN_H + MAX_H) / 2;

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [HEIGHT_W-1:0] height_q, height_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic [COL_W-1:0]    centre_q, centre_d;
    logic [5:0]          radius_q, radius_d;
    logic [COL_W-1:0]    spanHi_q, spanHi_d;
    logic                rdValid_q;

    logic [COL_W-1:0]    ramAddr;
    logic                ramWe;
    logic [HEIGHT_W-1:0] ramWdata;
    logic [HEIGHT_W-1:0] ramRdata;
    logic [HEIGHT_W-1:0] ramBdata;

    logic [LFSR_W-1:0]   lfsrStep;
    logic [K-1:0]        stepSel;
    int                  stepDelta;
    logic [HEIGHT_W-1:0] walkNext;
    int                  spanLo;
    int                  spanHi;
    int                  carveDepth;
    int                  carveVal;
    logic [HEIGHT_W-1:0] carvedH;

    assign lfsrStep  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    assign stepSel   = lfsrStep[K-1:0];
    assign stepDelta = (int'(stepSel) <= 2*STEP_MAX) ? int'(stepSel) - STEP_MAX : 0;
    assign walkNext  = HEIGHT_W'(clampInt(int'(height_q) + stepDelta, MIN_H, MAX_H));

    // Crater span is clipped to the map at both ends; depth tapers linearly to 0 at the rim
    assign spanLo     = (int'(crater_col_i) > int'(crater_r_i)) ? int'(crater_col_i) - int'(crater_r_i) : 0;
    assign spanHi     = (int'(crater_col_i) + int'(crater_r_i) > NUM_COLS-1) ? NUM_COLS-1
                                                                             : int'(crater_col_i) + int'(crater_r_i);
    assign carveDepth = int'(radius_q) - absInt(int'(col_q) - int'(centre_q));
    assign carveVal   = int'(ramRdata) - carveDepth;
    assign carvedH    = (carveVal < 0) ? '0 : HEIGHT_W'(carveVal);

`ifdef TERRAIN_SMOOTH_EN
    logic [HEIGHT_W-1:0] hPrev_q, hPrev_d;
    logic [HEIGHT_W-1:0] hPrev2_q, hPrev2_d;
    logic [HEIGHT_W-1:0] filtLeft;
    logic [HEIGHT_W-1:0] filtRight;
    logic [HEIGHT_W+1:0] filtSum;

    // Column being written lags the raw walk by one; edges reuse the edge sample itself
    assign filtLeft  = (col_q == CNT_W'(1)) ? hPrev_q : hPrev2_q;
    assign filtRight = (col_q == CNT_W'(NUM_COLS)) ? hPrev_q : height_q;
    assign filtSum   = {2'b00, filtLeft} + {1'b0, hPrev_q, 1'b0} + {2'b00, filtRight};
`endif

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        height_d     = height_q;
        col_d        = col_q;
        centre_d     = centre_q;
        radius_d     = radius_q;
        spanHi_d     = spanHi_q;
        ramAddr      = '0;
        ramWe        = 1'b0;
        ramWdata     = '0;
        crater_ack_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
`ifdef TERRAIN_SMOOTH_EN
        hPrev_d      = hPrev_q;
        hPrev2_d     = hPrev2_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    lfsr_d  = (seed_i == '0) ? LFSR_W'(1) : seed_i;
                    state_d = SEED;
                end else if (crater_req_i) begin
                    crater_ack_o = 1'b1;
                    centre_d     = crater_col_i;
                    radius_d     = crater_r_i;
                    col_d        = CNT_W'(spanLo);
                    spanHi_d     = COL_W'(spanHi);
                    state_d      = (int'(crater_col_i) >= NUM_COLS) ? FIN : CRD;
                end
            end
            SEED: begin
                busy_o   = 1'b1;
                height_d = HEIGHT_W'(MID_H);
                col_d    = '0;
                state_d  = GEN;
            end
            GEN: begin
                busy_o = 1'b1;
                col_d  = col_q + CNT_W'(1);
`ifdef TERRAIN_SMOOTH_EN
                if (col_q != CNT_W'(NUM_COLS)) begin
                    lfsr_d   = lfsrStep;
                    height_d = walkNext;
                end
                if (col_q != '0) begin
                    ramWe    = 1'b1;
                    ramAddr  = COL_W'(col_q - CNT_W'(1));
                    ramWdata = filtSum[HEIGHT_W+1:2];
                end
                hPrev2_d = hPrev_q;
                hPrev_d  = height_q;
                if (col_q == CNT_W'(NUM_COLS)) begin
                    state_d = FIN;
                end
`else
                ramWe    = 1'b1;
                ramAddr  = COL_W'(col_q);
                ramWdata = height_q;
                lfsr_d   = lfsrStep;
                height_d = walkNext;
                if (col_q == CNT_W'(NUM_COLS-1)) begin
                    state_d = FIN;
                end
`endif
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            CRD: begin
                busy_o  = 1'b1;
                ramAddr = COL_W'(col_q);
                state_d = CWR;
            end
            CWR: begin
                busy_o   = 1'b1;
                ramWe    = 1'b1;
                ramAddr  = COL_W'(col_q);
                ramWdata = carvedH;
                if (col_q == CNT_W'(spanHi_q)) begin
                    state_d = FIN;
                end else begin
                    col_d   = col_q + CNT_W'(1);
                    state_d = CRD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_W'(1);
            height_q  <= '0;
            col_q     <= '0;
            centre_q  <= '0;
            radius_q  <= '0;
            spanHi_q  <= '0;
            rdValid_q <= 1'b0;
`ifdef TERRAIN_SMOOTH_EN
            hPrev_q   <= '0;
            hPrev2_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            height_q  <= height_d;
            col_q     <= col_d;
            centre_q  <= centre_d;
            radius_q  <= radius_d;
            spanHi_q  <= spanHi_d;
            rdValid_q <= 1'b1;
`ifdef TERRAIN_SMOOTH_EN
            hPrev_q   <= hPrev_d;
            hPrev2_q  <= hPrev2_d;
`endif
        end
    end

    // RAM output register has no reset, so the read port is masked until the first clock after reset
    assign rd_height_o = rdValid_q ? ramBdata : '0;

    terrain_ram #(
        .DEPTH (NUM_COLS),
        .WIDTH (HEIGHT_W),
        .AW    (COL_W)
    ) u_ram (
        .clk_i     (clk_i),
        .a_addr_i  (ramAddr),
        .a_we_i    (ramWe),
        .a_wdata_i (ramWdata),
        .a_rdata_o (ramRdata),
        .b_addr_i  (rd_col_i),
        .b_rdata_o (ramBdata)
    );

endmodule

// File: tb/tb_terrain_gen.sv
// Directed bench for terrain_gen: a 16-column random-walk instance plus a flat (200) instance for carving.
module tb_terrain_gen;

    localparam int N  = 16;
    localparam int HW = 9;
    localparam int LW = 16;
    localparam int CW = 4;
`ifdef TERRAIN_SMOOTH_EN
    localparam int GEN_LAT = N + 3;
`else
    localparam int GEN_LAT = N + 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] seed = '0;
    logic          craterReq = 1'b0;
    logic [CW-1:0] craterCol = '0;
    logic [5:0]    craterR = '0;
    logic          craterAck, busy, done;
    logic [CW-1:0] rdCol = '0;
    logic [HW-1:0] rdHeight;

    logic          fStart = 1'b0;
    logic [LW-1:0] fSeed = '0;
    logic          fReq = 1'b0;
    logic [CW-1:0] fCol = '0;
    logic [5:0]    fR = '0;
    logic          fAck, fBusy, fDone;
    logic [CW-1:0] fRdCol = '0;
    logic [HW-1:0] fRdHeight;

    int errors = 0;
    int checks = 0;
    int gold [N];

    terrain_gen #(.NUM_COLS(N)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .seed_i(seed),
        .crater_req_i(craterReq), .crater_col_i(craterCol), .crater_r_i(craterR),
        .crater_ack_o(craterAck), .busy_o(busy), .done_o(done),
        .rd_col_i(rdCol), .rd_height_o(rdHeight)
    );

    terrain_gen #(.NUM_COLS(N), .MIN_H(200), .MAX_H(200)) dutFlat (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(fStart), .seed_i(fSeed),
        .crater_req_i(fReq), .crater_col_i(fCol), .crater_r_i(fR),
        .crater_ack_o(fAck), .busy_o(fBusy), .done_o(fDone),
        .rd_col_i(fRdCol), .rd_height_o(fRdHeight)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference walk: Galois LFSR (0xB400), step taken before drawing, 3-bit draw, clamp 120..400
    function automatic void buildGold(input logic [15:0] s);
        logic [15:0] l;
        int h, r, d, lft, rgt;
        int raw [N];
        l = (s == 16'd0) ? 16'd1 : s;
        h = 260;
        for (int c = 0; c < N; c++) begin
            raw[c] = h;
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
            r = int'(l[2:0]);
            d = (r <= 6) ? r - 3 : 0;
            h = h + d;
            if (h < 120) h = 120;
            if (h > 400) h = 400;
        end
        for (int c = 0; c < N; c++) begin
`ifdef TERRAIN_SMOOTH_EN
            lft = (c == 0) ? raw[0] : raw[c-1];
            rgt = (c == N-1) ? raw[N-1] : raw[c+1];
            gold[c] = (lft + 2*raw[c] + rgt) >> 2;
`else
            lft = 0;
            rgt = 0;
            gold[c] = raw[c];
`endif
        end
    endfunction

    task automatic applyStimulus(input bit onFlat, input logic [15:0] s, output int doneCycle);
        @(negedge clk);
        if (onFlat) begin fSeed = s; fStart = 1'b1; end
        else begin seed = s; start = 1'b1; end
        doneCycle = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            fStart = 1'b0;
            if ((onFlat ? fDone : done) === 1'b1) begin
                doneCycle = i;
                break;
            end
        end
    endtask

    task automatic readCol(input bit onFlat, input int c, output logic [31:0] v);
        @(negedge clk);
        if (onFlat) fRdCol = CW'(c);
        else rdCol = CW'(c);
        @(negedge clk);
        v = onFlat ? 32'(fRdHeight) : 32'(rdHeight);
    endtask

    task automatic carveFlat(input int col, input int r, output int ackCount, output int doneCycle);
        @(negedge clk);
        fCol = CW'(col);
        fR = 6'(r);
        fReq = 1'b1;
        #1;
        ackCount = (fAck === 1'b1) ? 1 : 0;
        doneCycle = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            fReq = 1'b0;
            if (fAck === 1'b1) ackCount++;
            if (fDone === 1'b1) begin
                doneCycle = i;
                break;
            end
        end
    endtask

    initial begin
        int dc, ac, ackCycle, carveDone, doneSeen;
        logic [31:0] v, prev;
        int expFlat [8];
        expFlat = '{198, 197, 196, 197, 198, 199, 200, 200};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ack", craterAck, 0);
        checkOutput("rst_rdh", rdHeight, 0);
        checkOutput("rst_lfsr", dut.lfsr_q, 1);
        rst_n = 1'b1;

        // Reset in the middle of generation
        @(negedge clk);
        seed = 16'hACE1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midgen_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_lfsr", dut.lfsr_q, 1);
        checkOutput("abort_rdh", rdHeight, 0);
        @(negedge clk);
        checkOutput("abort_rdh_next", rdHeight, 0);
        rst_n = 1'b1;
        doneSeen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);

        // Generation with seed 0xACE1
        applyStimulus(1'b0, 16'hACE1, dc);
        checkOutput("gen_done_cycle", dc, GEN_LAT);
        buildGold(16'hACE1);
        for (int c = 0; c < N; c++) begin
            readCol(1'b0, c, v);
            checkOutput($sformatf("ace1_h%0d", c), v, gold[c]);
            checkOutput($sformatf("ace1_range%0d", c), (v >= 120 && v <= 400), 1);
            if (c > 0)
                checkOutput($sformatf("ace1_slope%0d", c),
                            ((int'(v) - int'(prev)) <= 3 && (int'(prev) - int'(v)) <= 3), 1);
            prev = v;
        end

        // Seed 0 behaves as seed 1
        applyStimulus(1'b0, 16'h0000, dc);
        checkOutput("seed0_done_cycle", dc, GEN_LAT);
        buildGold(16'h0001);
        for (int c = 0; c < N; c++) begin
            readCol(1'b0, c, v);
            checkOutput($sformatf("seed0_h%0d", c), v, gold[c]);
        end

        // Crater request raised together with Start: generation wins, ack follows Done
        buildGold(16'h1234);
        @(negedge clk);
        seed = 16'h1234;
        start = 1'b1;
        craterReq = 1'b1;
        craterCol = 4'd5;
        craterR = 6'd0;
        dc = -1; ackCycle = -1; carveDone = -1; ac = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (ackCycle >= 0) craterReq = 1'b0;
            if (craterAck === 1'b1) begin
                ac++;
                if (ackCycle < 0) ackCycle = i;
            end
            if (done === 1'b1) begin
                if (dc < 0) dc = i;
                else begin
                    carveDone = i;
                    break;
                end
            end
        end
        craterReq = 1'b0;
        checkOutput("race_gen_done", dc, GEN_LAT);
        checkOutput("race_ack_cycle", ackCycle, GEN_LAT + 1);
        checkOutput("race_ack_count", ac, 1);
        checkOutput("race_r0_done", carveDone, GEN_LAT + 4);
        readCol(1'b0, 5, v);
        checkOutput("r0_col5", v, gold[5]);
        readCol(1'b0, 4, v);
        checkOutput("r0_col4", v, gold[4]);

        // Flat map 200, crater at column 2 radius 4
        applyStimulus(1'b1, 16'h5555, dc);
        checkOutput("flat_done_cycle", dc, GEN_LAT);
        carveFlat(2, 4, ac, dc);
        checkOutput("crater_ack_count", ac, 1);
        checkOutput("crater_done_cycle", dc, 15);
        for (int c = 0; c < 8; c++) begin
            readCol(1'b1, c, v);
            checkOutput($sformatf("crater_h%0d", c), v, expFlat[c]);
        end

        // Deep craters over the whole map floor at 0
        applyStimulus(1'b1, 16'h0001, dc);
        readCol(1'b1, 2, v);
        checkOutput("regen_h2", v, 200);
        carveFlat(8, 63, ac, dc);
        checkOutput("deep_done_cycle", dc, 2*N + 1);
        readCol(1'b1, 0, v);
        checkOutput("deep1_h0", v, 145);
        readCol(1'b1, 8, v);
        checkOutput("deep1_h8", v, 137);
        readCol(1'b1, 15, v);
        checkOutput("deep1_h15", v, 144);
        repeat (3) carveFlat(8, 63, ac, dc);
        for (int c = 0; c < N; c++) begin
            readCol(1'b1, c, v);
            checkOutput($sformatf("floor_h%0d", c), v, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
